fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Bit-reversal reorder buffer at the output end of the N-point pipelined FFT chain.
//  Accepts the two-lane (up/down) bit-reversed stream from the last butterfly block.
//  Emits it in natural order, two lanes per cycle, under valid/ready handshake.
//  Ping-pong banks: one frame fills while the previous frame drains.
// PARAMETERS
//  N      128  FFT length, power of 2, >= 4
//  LOG2N  7    log2(N)
//  NB     9    bits per real/imag component; sample = {re,im} = 2*NB bits
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  in_up      in   2*NB     X[bitrev(2j)], j = in-frame cycle index 0..N/2-1
//  in_down    in   2*NB     X[bitrev(2j+1)] (= up index + N/2)
//  in_valid   in   1        input pair valid
//  in_first   in   1        qualifies j=0 of a frame (with in_valid)
//  in_ready   out  1        write bank can accept
//  out_up     out  2*NB     X[k], k = out-frame index 0..N/2-1
//  out_down   out  2*NB     X[k+N/2]
//  out_valid  out  1        output pair valid
//  out_last   out  1        with out_valid at k = N/2-1
//  out_ready  in   1        downstream accepts
//  err_ovf    out  1        sticky: in_valid while !in_ready (pair dropped)
//  err_sync   out  1        sticky: in_first mid-frame
// BEHAVIOUR
//  - Reset (rst=0, async): banks EMPTY, wr_bank=0, rd_bank=0, wr_ptr=rd_ptr=0, state WAIT_SYNC.
//    All outputs 0 except in_ready=1. Memory contents are don't-care.
//    Reset mid-frame discards both banks.
//  - Write FSM: WAIT_SYNC -> FILL on in_valid&in_first; FILL -> WAIT_SYNC after pair j=N/2-1.
//    In WAIT_SYNC, in_valid pairs without in_first are dropped silently (no error).
//  - Accepting in_first also writes the j=0 pair.
//  - Write address: pair j goes to bank[wr_bank][bitrev_{LOG2N-1}(j)], storing {in_up,in_down}.
//  - Accepted last pair (j=N/2-1): mark bank FULL and toggle wr_bank.
//  - in_ready = (bank[wr_bank] == EMPTY). in_valid & !in_ready sets err_ovf; that pair is dropped.
//  - in_first accepted while FILL with j!=0: set err_sync, restart the current bank at j=0 with this pair.
//  - Read side: out_valid = (bank[rd_bank] == FULL).
//    {out_up,out_down} = bank[rd_bank][rd_ptr], combinational from registered rd_ptr.
//  - out_valid & out_ready: rd_ptr++.
//    At rd_ptr=N/2-1 (out_last=1): bank -> EMPTY, rd_ptr=0, rd_bank toggles.
//  - out_valid & !out_ready: hold data and rd_ptr stable.
//  - out_up/out_down = 0 whenever out_valid=0.
//  - Latency: first output pair is valid the cycle after the last input pair of its frame is written.
//  - Throughput: continuous 1 pair/cycle in and out with out_ready=1; in_ready never drops.
//  - Simultaneous events:
//    - Same cycle a bank completes filling and the other bank completes draining: both transitions apply.
//    - Same bank freed by read and requested by write in one cycle: in_ready reflects registered state,
//      so the write waits one cycle.
//  - Errors clear only on reset. No arithmetic; data passes bit-exact.
// STRUCTURE
//  - Shared package/defines: N, LOG2N, NB, sample width 2*NB,
//    bank-state encoding (EMPTY/FULL), write-FSM encoding (WAIT_SYNC/FILL).
//  - One sub-module: bitrev #(W) — pure combinational W-bit reversal, used on wr_ptr with W=LOG2N-1.
//  - Storage: reg array [0:1][0:N/2-1] of 4*NB bits.
// TESTING
//  1 Frame with X[i]=i (re=i, im=0) fed in bit-reversed pair order, out_ready=1
//    -> out_up re 0..63, out_down re 64..127, out_last at k=63, first out_valid 1 cycle after j=63.
//  2 Three back-to-back frames, out_ready=1 -> in_ready stays 1, 192 output pairs, no gaps after first frame.
//  3 out_ready low for 100 cycles starting mid-drain
//    -> outputs held stable, in_ready=0 once both banks FULL.
//    -> extra in_valid sets err_ovf=1 and drops the pair; remaining data intact.
//  4 in_first re-asserted at j=20 -> err_sync=1, frame restarts; emitted frame equals the second one only.
//  5 in_valid pulses before any in_first after reset -> ignored, no errors, out_valid stays 0.
//  6 rst asserted low at j=30 of frame 2 while frame 1 drains
//    -> next edge-independent: out_valid=0, outputs 0, errors 0.
//    -> next full frame after reset reorders correctly.

Source files
------------

// File: rtl/fft_out_reorder_pkg.sv
// Shared constants and state encodings for the FFT output reorder buffer.
package fft_out_reorder_pkg;

    // Default FFT geometry: length, log2 length, bits per real/imag component
    localparam int FFT_N     = 128;
    localparam int FFT_LOG2N = 7;
    localparam int FFT_NB    = 9;

    // Per-bank occupancy
    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_st_e;

    // Write-side frame tracking
    typedef enum logic {
        WAIT_SYNC = 1'b0,
        FILL      = 1'b1
    } wr_st_e;

endpackage

// File: rtl/fft_out_reorder_bitrev.sv
// Pure combinational W-bit reversal, used to scatter input pairs into natural order.
module fft_out_reorder_bitrev #(
    parameter int W = 6
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Mirror bit i onto bit W-1-i
    always_comb begin
        dout = '0;
        for (int i = 0; i < W; i++) begin
            dout[i] = din[W-1-i];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong bit-reversal reorder buffer at the FFT output: one bank fills with
// the bit-reversed pair stream while the other drains in natural order.
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int NB    = FFT_NB
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*NB-1:0] in_up,
    input  logic [2*NB-1:0] in_down,
    input  logic            in_valid,
    input  logic            in_first,
    output logic            in_ready,
    output logic [2*NB-1:0] out_up,
    output logic [2*NB-1:0] out_down,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic            err_ovf,
    output logic            err_sync
);

    // Pair index width: N/2 pairs per frame
    localparam int PW = LOG2N - 1;
    localparam logic [PW-1:0] PTR_LAST = {PW{1'b1}};

    // Each word holds one {up,down} pair; bank index first, pair slot second
    logic [4*NB-1:0] mem [0:1][0:N/2-1];

    wr_st_e        wr_st_q,    wr_st_d;
    bank_st_e      bank_st_q [0:1];
    bank_st_e      bank_st_d [0:1];
    logic          wr_bank_q,  wr_bank_d;
    logic          rd_bank_q,  rd_bank_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic          err_ovf_q,  err_ovf_d;
    logic          err_sync_q, err_sync_d;

    logic          wr_take;
    logic          rd_take;
    logic [PW-1:0] wr_j;
    logic [PW-1:0] wr_addr;
    logic [4*NB-1:0] rd_word;

    // A fresh in_first always lands at slot 0, even when it interrupts a frame
    assign wr_j = in_first ? '0 : wr_ptr_q;

    fft_out_reorder_bitrev #(.W(PW)) u_bitrev (
        .din  (wr_j),
        .dout (wr_addr)
    );

    // Handshake and read-port outputs, all derived from registered bank state
    always_comb begin
        in_ready  = (bank_st_q[wr_bank_q] == BANK_EMPTY);
        out_valid = (bank_st_q[rd_bank_q] == BANK_FULL);
        out_last  = out_valid && (rd_ptr_q == PTR_LAST);
        rd_word   = mem[rd_bank_q][rd_ptr_q];
        {out_up, out_down} = out_valid ? rd_word : '0;
        wr_take   = in_valid && in_ready && (in_first || (wr_st_q == FILL));
        rd_take   = out_valid && out_ready;
        err_ovf   = err_ovf_q;
        err_sync  = err_sync_q;
    end

    // Next-state: write and read sides touch different banks, so both may retire in one cycle
    always_comb begin
        wr_st_d    = wr_st_q;
        bank_st_d  = bank_st_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_ovf_d  = err_ovf_q;
        err_sync_d = err_sync_q;

        // Pair offered while the write bank is still occupied is lost
        if (in_valid && !in_ready) begin
            err_ovf_d = 1'b1;
        end

        if (wr_take) begin
            if (in_first && (wr_st_q == FILL) && (wr_ptr_q != '0)) begin
                err_sync_d = 1'b1;
            end
            if (wr_j == PTR_LAST) begin
                bank_st_d[wr_bank_q] = BANK_FULL;
                wr_bank_d            = ~wr_bank_q;
                wr_ptr_d             = '0;
                wr_st_d              = WAIT_SYNC;
            end else begin
                wr_ptr_d = wr_j + 1'b1;
                wr_st_d  = FILL;
            end
        end

        if (rd_take) begin
            if (rd_ptr_q == PTR_LAST) begin
                bank_st_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d            = ~rd_bank_q;
                rd_ptr_d             = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Control state; reset discards both banks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_st_q      <= WAIT_SYNC;
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_ovf_q    <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            wr_st_q      <= wr_st_d;
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_ovf_q    <= err_ovf_d;
            err_sync_q   <= err_sync_d;
        end
    end

    // Storage: each pair lands at its bit-reversed slot so the reader walks linearly
    always_ff @(posedge clk) begin
        if (wr_take) begin
            mem[wr_bank_q][wr_addr] <= {in_up, in_down};
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: frame-level reference model plus
// a small vector table and directed multi-cycle sequences.
module tb_fft_out_reorder;

    localparam int N     = 128;
    localparam int LOG2N = 7;
    localparam int NB    = 9;
    localparam int SW    = 2*NB;
    localparam int H     = N/2;

    typedef logic [SW-1:0] samp_t;

    typedef struct {
        logic v;
        logic f;
        logic ordy;
        logic exp_ready;
        logic exp_valid;
        logic exp_ovf;
        logic exp_sync;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    samp_t in_up = '0, in_down = '0;
    logic  in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b0;
    logic  in_ready, out_valid, out_last, err_ovf, err_sync;
    samp_t out_up, out_down;

    always #5 clk = ~clk;

    fft_out_reorder #(.N(N), .LOG2N(LOG2N), .NB(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_up     (in_up),
        .in_down   (in_down),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_up    (out_up),
        .out_down  (out_down),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_ovf   (err_ovf),
        .err_sync  (err_sync)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: completed frames in natural order, up to two buffered
    samp_t m_fr [2][N];
    samp_t fill_buf [N];
    int    m_head, m_cnt, m_k, m_j;
    bit    m_filling, m_ovf, m_sync;

    logic  obs_in_ready, obs_out_valid, obs_err_ovf, obs_err_sync;
    int    dut_out_cnt;
    int    ready_low_cnt;
    samp_t frame [N];
    vec_t  tbl [6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N-1-b);
        return r;
    endfunction

    function automatic logic rnd_rdy();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic model_reset();
        m_head = 0; m_cnt = 0; m_k = 0; m_j = 0;
        m_filling = 0; m_ovf = 0; m_sync = 0;
    endtask

    // One clock cycle: drive, compare at negedge against model, advance model
    task automatic step(input logic v, input logic f, input samp_t up, input samp_t dn, input logic ordy);
        logic  ev, er;
        samp_t eu, ed;
        bit    done;
        in_valid = v; in_first = f; in_up = up; in_down = dn; out_ready = ordy;
        @(negedge clk);
        ev = (m_cnt > 0);
        er = (m_cnt < 2);
        eu = ev ? m_fr[m_head][m_k]   : '0;
        ed = ev ? m_fr[m_head][m_k+H] : '0;
        chk("out_valid", out_valid, ev);
        chk("in_ready",  in_ready,  er);
        chk("out_last",  out_last,  ev && (m_k == H-1));
        chk("out_up",    out_up,    eu);
        chk("out_down",  out_down,  ed);
        chk("err_ovf",   err_ovf,   m_ovf);
        chk("err_sync",  err_sync,  m_sync);
        obs_in_ready = in_ready; obs_out_valid = out_valid;
        obs_err_ovf = err_ovf;   obs_err_sync = err_sync;
        if (out_valid && out_ready) dut_out_cnt++;
        if (!in_ready) ready_low_cnt++;
        done = 0;
        if (v) begin
            if (!er) m_ovf = 1;
            else if (f || m_filling) begin
                if (f) begin
                    if (m_filling && m_j != 0) m_sync = 1;
                    m_filling = 1;
                    m_j = 0;
                end
                // pair j carries X[bitrev(2j)] and X[bitrev(2j)+N/2]
                fill_buf[brev(2*m_j)]     = up;
                fill_buf[brev(2*m_j) + H] = dn;
                m_j++;
                if (m_j == H) begin done = 1; m_filling = 0; m_j = 0; end
            end
        end
        if (ev && ordy) begin
            m_k++;
            if (m_k == H) begin m_k = 0; m_head ^= 1; m_cnt--; end
        end
        if (done) begin
            for (int i = 0; i < N; i++) m_fr[(m_head + m_cnt) % 2][i] = fill_buf[i];
            m_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        in_valid = 0; in_first = 0;
        rst = 0; #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_up",    out_up,    0);
        chk("rst_out_down",  out_down,  0);
        chk("rst_err_ovf",   err_ovf,   0);
        chk("rst_err_sync",  err_sync,  0);
        chk("rst_in_ready",  in_ready,  1);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) frame[i] = samp_t'($urandom);
    endtask

    // rmode 0: one pair per cycle, out_ready=1; rmode 1: random gaps, ready and stray syncs
    task automatic feed_frame(input int rmode);
        for (int j = 0; j < H; j++) begin
            if (rmode != 0)
                while ($urandom_range(0, 3) == 0) step(0, 0, samp_t'($urandom), samp_t'($urandom), rnd_rdy());
            step(1, (j == 0) || (rmode != 0 && $urandom_range(0, 99) == 0),
                 frame[brev(2*j)], frame[brev(2*j) + H], (rmode != 0) ? rnd_rdy() : 1'b1);
        end
    endtask

    task automatic drain(input int rmode);
        for (int c = 0; c < 8*N && m_cnt > 0; c++) step(0, 0, '0, '0, (rmode != 0) ? rnd_rdy() : 1'b1);
        chk("drain_done", m_cnt, 0);
        step(0, 0, '0, '0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // in_valid without in_first after reset: ignored, no errors, nothing emitted
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        @(posedge clk); #1;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].f, samp_t'($urandom), samp_t'($urandom), tbl[i].ordy);
            chk("tbl_in_ready",  obs_in_ready,  tbl[i].exp_ready);
            chk("tbl_out_valid", obs_out_valid, tbl[i].exp_valid);
            chk("tbl_err_ovf",   obs_err_ovf,   tbl[i].exp_ovf);
            chk("tbl_err_sync",  obs_err_sync,  tbl[i].exp_sync);
        end

        // X[i] = i on the real part, one frame, first output the cycle after the last pair
        for (int i = 0; i < N; i++) frame[i] = samp_t'(i) << NB;
        dut_out_cnt = 0;
        feed_frame(0);
        step(0, 0, '0, '0, 1);
        chk("t1_latency", obs_out_valid, 1);
        drain(0);
        chk("t1_count", dut_out_cnt, H);

        // Three back-to-back frames: in_ready never drops
        dut_out_cnt = 0; ready_low_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            feed_frame(0);
        end
        drain(0);
        chk("t2_ready_low", ready_low_cnt, 0);
        chk("t2_count", dut_out_cnt, 3*H);

        // Downstream stalls for 100 cycles mid-drain, both banks fill, extra input overflows
        dut_out_cnt = 0;
        rand_frame();
        feed_frame(0);
        rand_frame();
        for (int j = 0; j < H; j++)
            step(1, j == 0, frame[brev(2*j)], frame[brev(2*j) + H], j < 20);
        for (int c = 0; c < 56; c++) begin
            step(1, c == 0, samp_t'($urandom), samp_t'($urandom), 0);
            if (c == 0) chk("t3_in_ready_low", obs_in_ready, 0);
        end
        chk("t3_err_ovf", obs_err_ovf, 1);
        chk("t3_err_sync", obs_err_sync, 0);
        drain(0);
        chk("t3_count", dut_out_cnt, 2*H);

        // in_first re-asserted at j=20: only the second frame comes out
        apply_reset();
        dut_out_cnt = 0;
        rand_frame();
        for (int j = 0; j < 20; j++)
            step(1, j == 0, frame[brev(2*j)], frame[brev(2*j) + H], 1);
        rand_frame();
        feed_frame(0);
        step(0, 0, '0, '0, 1);
        chk("t4_err_sync", obs_err_sync, 1);
        drain(0);
        chk("t4_count", dut_out_cnt, H);

        // Reset at j=30 of frame 2 while frame 1 drains, then a clean frame
        apply_reset();
        rand_frame();
        feed_frame(0);
        rand_frame();
        for (int j = 0; j < 30; j++)
            step(1, j == 0, frame[brev(2*j)], frame[brev(2*j) + H], 1);
        apply_reset();
        dut_out_cnt = 0;
        rand_frame();
        feed_frame(0);
        drain(0);
        chk("t6_count", dut_out_cnt, H);

        // Randomized traffic against the model
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            feed_frame(1);
        end
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
